// File: rtl/wall_map_if.sv
// Wall-map arbiter bus: VGA lookup, game requesters, clear control and RAM port.
// slave = arbiter side, master = everything that talks to the arbiter.
interface wall_map_if #(parameter int N_REQ = 3);
    logic [5:0]         i_vga_x;
    logic [5:0]         i_vga_y;
    logic               o_vga_is_wall;
    logic [N_REQ-1:0]   i_req;
    logic [6*N_REQ-1:0] i_req_x;
    logic [6*N_REQ-1:0] i_req_y;
    logic [N_REQ-1:0]   i_req_we;
    logic [N_REQ-1:0]   i_req_wdata;
    logic [N_REQ-1:0]   o_gnt;
    logic [N_REQ-1:0]   o_rvalid;
    logic               o_rdata;
    logic               i_clear;
    logic               i_clear_value;
    logic               o_clear_busy;
    logic [11:0]        o_ram_addr;
    logic               o_ram_we;
    logic               o_ram_wdata;
    logic               i_ram_rdata;

    modport slave (
        input  i_vga_x, i_vga_y, i_req, i_req_x, i_req_y, i_req_we, i_req_wdata,
               i_clear, i_clear_value, i_ram_rdata,
        output o_vga_is_wall, o_gnt, o_rvalid, o_rdata, o_clear_busy,
               o_ram_addr, o_ram_we, o_ram_wdata
    );

    modport master (
        output i_vga_x, i_vga_y, i_req, i_req_x, i_req_y, i_req_we, i_req_wdata,
               i_clear, i_clear_value, i_ram_rdata,
        input  o_vga_is_wall, o_gnt, o_rvalid, o_rdata, o_clear_busy,
               o_ram_addr, o_ram_we, o_ram_wdata
    );
endinterface

// File: rtl/wall_map_arbiter.sv
// Single-port wall-map RAM arbiter: VGA lookups first, then round-robin game
// requesters, with a sweep sequencer that fills the playable map.
//   state | meaning
//   ARB   | VGA slot or one round-robin game grant per cycle
//   CLEAR | sweeping {cy,cx} over the playable map with the latched fill value
module wall_map_arbiter #(
    parameter int MAP_W = 64,
    parameter int MAP_H = 44,
    parameter int N_REQ = 3
) (
    input  logic      clk,
    input  logic      rst_n,
    wall_map_if.slave bus
);
    localparam int RR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {ARB, CLEAR} state_t;

    state_t           state_q, state_d;
    logic [11:0]      last_vga_addr_q, last_vga_addr_d;
    logic             vga_rd_q;
    logic             vga_hold_q, vga_hold_d;
    logic [RR_W-1:0]  rr_q, rr_d;
    logic [N_REQ-1:0] rd_pend_q, rd_pend_d;
    logic             oob_q, oob_d;
    logic [5:0]       cx_q, cx_d, cy_q, cy_d;
    logic             fill_q, fill_d;

    logic [11:0] vga_addr;
    logic        vga_slot;

    assign vga_addr = {bus.i_vga_y, bus.i_vga_x};
    assign vga_slot = (vga_addr != last_vga_addr_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ARB;
            last_vga_addr_q <= '0;
            vga_rd_q        <= 1'b0;
            vga_hold_q      <= 1'b0;
            rr_q            <= '0;
            rd_pend_q       <= '0;
            oob_q           <= 1'b0;
            cx_q            <= '0;
            cy_q            <= '0;
            fill_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            last_vga_addr_q <= last_vga_addr_d;
            vga_rd_q        <= vga_slot;
            vga_hold_q      <= vga_hold_d;
            rr_q            <= rr_d;
            rd_pend_q       <= rd_pend_d;
            oob_q           <= oob_d;
            cx_q            <= cx_d;
            cy_q            <= cy_d;
            fill_q          <= fill_d;
        end
    end

    always_comb begin
        logic       found;
        logic       in_map;
        logic [5:0] gx;
        logic [5:0] gy;
        int         idx;

        state_d         = state_q;
        last_vga_addr_d = last_vga_addr_q;
        vga_hold_d      = vga_rd_q ? bus.i_ram_rdata : vga_hold_q;
        rr_d            = rr_q;
        rd_pend_d       = '0;
        oob_d           = 1'b0;
        cx_d            = cx_q;
        cy_d            = cy_q;
        fill_d          = fill_q;
        bus.o_gnt       = '0;
        bus.o_ram_addr  = '0;
        bus.o_ram_we    = 1'b0;
        bus.o_ram_wdata = 1'b0;
        found           = 1'b0;
        in_map          = 1'b0;
        gx              = '0;
        gy              = '0;
        idx             = 0;

        if (vga_slot) begin
            bus.o_ram_addr  = vga_addr;
            last_vga_addr_d = vga_addr;
        end else if (bus.i_clear) begin
            // the restart cycle itself is left idle; the sweep begins next cycle
        end else if (state_q == CLEAR) begin
            bus.o_ram_addr  = {cy_q, cx_q};
            bus.o_ram_we    = 1'b1;
            bus.o_ram_wdata = fill_q;
            if (cx_q == 6'(MAP_W - 1)) begin
                cx_d = '0;
                cy_d = cy_q + 6'd1;
                if (cy_q == 6'(MAP_H - 1)) begin
                    cy_d    = '0;
                    state_d = ARB;
                end
            end else begin
                cx_d = cx_q + 6'd1;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                idx = (int'(rr_q) + i) % N_REQ;
                if (!found && bus.i_req[idx]) begin
                    found          = 1'b1;
                    gx             = bus.i_req_x[6*idx +: 6];
                    gy             = bus.i_req_y[6*idx +: 6];
                    in_map         = (gy < 6'(MAP_H));
                    bus.o_gnt[idx] = 1'b1;
                    bus.o_ram_addr = {gy, gx};
                    if (bus.i_req_we[idx]) begin
                        bus.o_ram_we    = in_map;
                        bus.o_ram_wdata = bus.i_req_wdata[idx];
                    end else begin
                        rd_pend_d[idx] = 1'b1;
                        oob_d          = !in_map;
                    end
                    rr_d = RR_W'((idx + 1) % N_REQ);
                end
            end
        end

        if (bus.i_clear) begin
            state_d = CLEAR;
            cx_d    = '0;
            cy_d    = '0;
            fill_d  = bus.i_clear_value;
        end
    end

    // rows past the playable field read back as wall
    assign bus.o_rvalid      = rd_pend_q;
    assign bus.o_rdata       = (|rd_pend_q) & (oob_q | bus.i_ram_rdata);
    assign bus.o_vga_is_wall = vga_rd_q ? bus.i_ram_rdata : vga_hold_q;
    assign bus.o_clear_busy  = (state_q == CLEAR);
endmodule

// File: tb/tb_wall_map_arbiter.sv
// Directed bench for wall_map_arbiter with a synchronous single-port RAM model.
module tb_wall_map_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic mem [0:4095];

    always #5 clk = ~clk;

    wall_map_if #(.N_REQ(3)) bus ();

    wall_map_arbiter #(.MAP_W(64), .MAP_H(44), .N_REQ(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 1'b0;
            mem[12'h001] <= 1'b1;
            mem[12'h002] <= 1'b1;
            mem[12'h004] <= 1'b1;
            mem[12'h046] <= 1'b1;
            bus.i_ram_rdata <= 1'b0;
        end else begin
            if (bus.o_ram_we) mem[bus.o_ram_addr] <= bus.o_ram_wdata;
            bus.i_ram_rdata <= mem[bus.o_ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic set_req(input int k, input logic [5:0] x, input logic [5:0] y,
                           input logic we, input logic wd);
        bus.i_req_x[6*k +: 6] = x;
        bus.i_req_y[6*k +: 6] = y;
        bus.i_req_we[k]       = we;
        bus.i_req_wdata[k]    = wd;
    endtask

    initial begin
        int  busy_cnt;
        int  addr_err;
        int  gnt_err;
        logic done;

        bus.i_vga_x = '0;
        bus.i_vga_y = '0;
        bus.i_req = '0;
        bus.i_req_x = '0;
        bus.i_req_y = '0;
        bus.i_req_we = '0;
        bus.i_req_wdata = '0;
        bus.i_clear = 1'b0;
        bus.i_clear_value = 1'b0;

        settle();
        settle();
        check("rst_rvalid", bus.o_rvalid, 0);
        check("rst_rdata", bus.o_rdata, 0);
        check("rst_vga", bus.o_vga_is_wall, 0);
        check("rst_busy", bus.o_clear_busy, 0);
        check("rst_gnt", bus.o_gnt, 0);
        check("rst_we", bus.o_ram_we, 0);
        next();
        rst_n = 1'b1;

        // VGA lookup
        next(); bus.i_vga_x = 6'd1; settle();
        check("vga_addr", bus.o_ram_addr, 12'h001);
        check("vga_we", bus.o_ram_we, 0);
        next(); settle();
        check("vga_wall", bus.o_vga_is_wall, 1);
        next(); settle();
        check("vga_hold", bus.o_vga_is_wall, 1);

        // round robin, all reads
        next();
        set_req(0, 6'd2, 6'd0, 1'b0, 1'b0);
        set_req(1, 6'd3, 6'd0, 1'b0, 1'b0);
        set_req(2, 6'd4, 6'd0, 1'b0, 1'b0);
        bus.i_req = 3'b111;
        settle();
        check("rr_gnt0", bus.o_gnt, 3'b001);
        check("rr_addr0", bus.o_ram_addr, 12'h002);
        next(); settle();
        check("rr_gnt1", bus.o_gnt, 3'b010);
        check("rr_rv0", bus.o_rvalid, 3'b001);
        check("rr_rd0", bus.o_rdata, 1);
        next(); settle();
        check("rr_gnt2", bus.o_gnt, 3'b100);
        check("rr_rv1", bus.o_rvalid, 3'b010);
        check("rr_rd1", bus.o_rdata, 0);
        next(); settle();
        check("rr_gnt3", bus.o_gnt, 3'b001);
        check("rr_rv2", bus.o_rvalid, 3'b100);
        check("rr_rd2", bus.o_rdata, 1);
        next(); bus.i_req = 3'b000; settle();
        check("rr_gnt_idle", bus.o_gnt, 0);
        check("rr_rv3", bus.o_rvalid, 3'b001);

        // VGA preempts a pending game read
        next();
        set_req(1, 6'd6, 6'd1, 1'b0, 1'b0);
        bus.i_req = 3'b010;
        bus.i_vga_x = 6'd3;
        settle();
        check("pre_gnt", bus.o_gnt, 0);
        check("pre_addr", bus.o_ram_addr, 12'h003);
        next(); settle();
        check("pre_gnt1", bus.o_gnt, 3'b010);
        check("pre_addr1", bus.o_ram_addr, 12'h046);
        check("pre_vga", bus.o_vga_is_wall, 0);
        next(); bus.i_req = 3'b000; settle();
        check("pre_rv", bus.o_rvalid, 3'b010);
        check("pre_rd", bus.o_rdata, 1);
        check("pre_vga_hold", bus.o_vga_is_wall, 0);

        // write then read back
        next();
        set_req(0, 6'd5, 6'd7, 1'b1, 1'b1);
        bus.i_req = 3'b001;
        settle();
        check("wr_gnt", bus.o_gnt, 3'b001);
        check("wr_we", bus.o_ram_we, 1);
        check("wr_addr", bus.o_ram_addr, 12'h1C5);
        check("wr_data", bus.o_ram_wdata, 1);
        next();
        set_req(0, 6'd0, 6'd0, 1'b0, 1'b0);
        set_req(2, 6'd5, 6'd7, 1'b0, 1'b0);
        bus.i_req = 3'b100;
        settle();
        check("rb_gnt", bus.o_gnt, 3'b100);
        check("wr_no_rv", bus.o_rvalid, 0);
        next(); bus.i_req = 3'b000; settle();
        check("rb_rv", bus.o_rvalid, 3'b100);
        check("rb_rd", bus.o_rdata, 1);

        // out-of-range rows
        next();
        set_req(1, 6'd0, 6'd44, 1'b0, 1'b0);
        bus.i_req = 3'b010;
        settle();
        check("oob_gnt", bus.o_gnt, 3'b010);
        check("oob_rd_we", bus.o_ram_we, 0);
        next();
        set_req(1, 6'd0, 6'd50, 1'b1, 1'b1);
        settle();
        check("oob_rv", bus.o_rvalid, 3'b010);
        check("oob_rd", bus.o_rdata, 1);
        check("oob_wgnt", bus.o_gnt, 3'b010);
        check("oob_we", bus.o_ram_we, 0);
        next();
        bus.i_req = 3'b000;
        set_req(1, 6'd0, 6'd0, 1'b0, 1'b0);
        settle();
        check("idle_rv", bus.o_rvalid, 0);
        check("idle_rd", bus.o_rdata, 0);
        check("oob_mem", mem[12'hC80], 0);

        // clear sweep
        next();
        bus.i_clear = 1'b1;
        bus.i_clear_value = 1'b0;
        settle();
        check("clr_pulse_busy", bus.o_clear_busy, 0);
        busy_cnt = 0;
        addr_err = 0;
        gnt_err = 0;
        done = 1'b0;
        for (int c = 0; c < 4000 && !done; c++) begin
            next();
            if (c == 0) bus.i_clear = 1'b0;
            if (c == 100) begin
                set_req(0, 6'd1, 6'd1, 1'b0, 1'b0);
                bus.i_req = 3'b001;
            end
            settle();
            if (bus.o_clear_busy) begin
                if (bus.o_ram_addr != busy_cnt[11:0] || !bus.o_ram_we || bus.o_ram_wdata)
                    addr_err++;
                if (bus.o_gnt != 0) gnt_err++;
                busy_cnt++;
            end else if (busy_cnt > 0) begin
                check("clr_first_gnt", bus.o_gnt, 3'b001);
                done = 1'b1;
            end
        end
        check("clr_done", done, 1);
        check("clr_cycles", busy_cnt, 2816);
        check("clr_addr_err", addr_err, 0);
        check("clr_gnt_err", gnt_err, 0);
        check("clr_mem_1c5", mem[12'h1C5], 0);
        check("clr_mem_046", mem[12'h046], 0);
        next(); bus.i_req = 3'b000; settle();
        check("clr_rv", bus.o_rvalid, 3'b001);
        check("clr_rd", bus.o_rdata, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/wall_map_arbiter.md
Name: wall_map_arbiter

Overview:
- Shares the single-port, synchronous wall-map RAM between the VGA renderer and the game-side requesters.
- Requesters: tank0 move check, tank1 move check, and the shell engine.
- The VGA read slot has absolute priority, so the renderer's wall bit is always ready by the first pixel of each grid cell.
- Game requesters are served round-robin in the remaining cycles. A clear sequencer sweeps the map to a fill value at game start.

Parameters:
MAP_W, 64, map width in grids (x is 6 bits)
MAP_H, 44, playable map height in grids (48 display rows minus the 4-row status bar)
N_REQ, 3, game-side requesters (index 0 tank0, 1 tank1, 2 shell engine)

Ports:
clk  in  1  system clock (pixel clock)
rst_n  in  1  asynchronous active-low reset
i_vga_x  in  6  VGA requested grid x
i_vga_y  in  6  VGA requested grid y (game-field row)
o_vga_is_wall  out  1  wall bit for the current VGA request
i_req  in  N_REQ  per-requester request, level
i_req_x  in  6*N_REQ  packed x, requester k at [6k+5:6k]
i_req_y  in  6*N_REQ  packed y, same packing
i_req_we  in  N_REQ  1 = write, 0 = read
i_req_wdata  in  N_REQ  write data per requester
o_gnt  out  N_REQ  one-hot grant pulse
o_rvalid  out  N_REQ  one-hot read-data-valid pulse
o_rdata  out  1  read data, shared across requesters
i_clear  in  1  start-clear pulse
i_clear_value  in  1  fill value, sampled on i_clear
o_clear_busy  out  1  high while a clear is in progress
o_ram_addr  out  12  RAM address {y,x}
o_ram_we  out  1  RAM write enable
o_ram_wdata  out  1  RAM write data
i_ram_rdata  in  1  RAM read data, valid the cycle after the address is presented

Behaviour:
- Reset values:
  - All outputs 0.
  - Internal state: last_vga_addr = 0, vga_hold = 0, rr pointer = 0, FSM = ARB, clear counters = 0.
- RAM outputs are driven combinationally from the slot decision made in the same cycle.
- VGA slot:
  - A VGA slot is taken in cycle t when {i_vga_y,i_vga_x} != last_vga_addr. In that case: o_ram_addr = {i_vga_y,i_vga_x}, o_ram_we = 0, and last_vga_addr updates.
  - In cycle t+1: o_vga_is_wall = i_ram_rdata, and the same value is registered into vga_hold.
  - Otherwise o_vga_is_wall = vga_hold. Latency from address change to valid bit is exactly 1 cycle.
  - A VGA slot preempts both game grants and clear writes in that cycle.
- FSM ARB, game slot (cycles with no VGA slot):
  - Scan i_req from index rr upward, wrapping; grant the first asserted requester k.
  - o_gnt[k] is high for that one cycle; rr becomes (k+1) mod N_REQ.
  - No requests in a cycle: rr is unchanged.
- Requester rules:
  - Requester holds req, x, y, we and wdata stable until it sees gnt.
  - It may drop or re-raise req in the cycle after gnt.
  - A req held through gnt is a new request.
- Read grant at t: o_rvalid[k] = 1 and o_rdata = i_ram_rdata at t+1.
- Write grant: o_ram_we = 1, o_ram_wdata = i_req_wdata[k]; no rvalid is issued.
- Out-of-range (y >= MAP_H): still granted normally, but no RAM write occurs (o_ram_we forced 0).
  - Reads return o_rdata = 1 (boundary = wall) at t+1, regardless of RAM.
- o_rdata is 0 in cycles with no rvalid.
- FSM CLEAR:
  - Entered from any state on i_clear. The fill value is latched; counters cx = 0, cy = 0.
  - Each non-VGA cycle: write {cy,cx} with the fill value; cx increments, wrapping at MAP_W-1 with cy increment.
  - After the write to {MAP_H-1, MAP_W-1}, return to ARB the next cycle.
  - No game grants are issued while in CLEAR; requests stay pending.
  - o_clear_busy = (FSM == CLEAR). A clear takes MAP_W*MAP_H write cycles plus any VGA-stolen cycles.
  - i_clear while in CLEAR restarts the sweep at {0,0} with the new fill value.
- Reset mid-operation: immediate return to reset values. Pending grants or rvalids are dropped, and a clear is abandoned.
- Address packing: o_ram_addr = {y[5:0], x[5:0]}. Unused rows 44..63 are never written by this block.

Test Plan:
- VGA only: step i_vga_x 0->1 with RAM[{0,1}] = 1 -> o_ram_addr = 0x001 that cycle; o_vga_is_wall = 1 the next cycle, held while the address is unchanged.
- Round-robin: i_req = 3'b111 held, all reads -> grants in order 001, 010, 100, 001; each o_rvalid one cycle after its o_gnt.
- VGA preemption: i_req[1] read pending, and VGA address changes in the same cycle -> o_gnt = 0 that cycle; o_gnt[1] the following cycle; VGA data correct.
- Write then read: req0 writes 1 at (x=5,y=7), then req2 reads (5,7) -> o_ram_we = 1, o_ram_addr = 0x1C5; read returns o_rdata = 1 with o_rvalid[2].
- Out of range: req1 reads y = 44 with RAM = 0 -> o_rdata = 1; write to y = 50 -> o_ram_we stays 0.
- Clear: i_clear with i_clear_value = 0, VGA idle -> o_clear_busy high for exactly 2816 cycles; addresses 0x000..0xAFF with row wrap at x = 63; an i_req raised meanwhile is granted in the first cycle after busy falls.
